// File: rtl/ram_dp_pkg.sv
// Shared types, RDW mode encodings and the byte-parity helper for the dual-port RAM.
package ram_dp_pkg;

   typedef enum logic {CLEAR, RUN} ram_state_e;

   localparam int RDW_OLD = 0;
   localparam int RDW_NEW = 1;

   // Even parity per byte; lanes at or above nbytes read back as 0.
   function automatic logic [31:0] byte_parity(input logic [255:0] data, input int unsigned nbytes);
      logic [31:0] p;
      p = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < nbytes) p[i] = ^data[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/ram_dp_rdpipe.sv
// RD_LAT-deep read-result pipeline; the last stage holds its data between valid strobes.
module ram_dp_rdpipe #(
   parameter int W      = 8,
   parameter int RD_LAT = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   output logic [W-1:0] out_data
);

   localparam int unsigned LAT = RD_LAT;

   logic [LAT-1:0]        v_q, v_d;
   logic [LAT-1:0][W-1:0] d_q, d_d;

   always_comb begin
      v_d    = v_q;
      d_d    = d_q;
      v_d[0] = in_valid;
      if (in_valid) d_d[0] = in_data;
      for (int unsigned i = 1; i < LAT; i++) begin
         v_d[i] = v_q[i-1];
         if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= '0;
         d_q <= '0;
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   assign out_valid = v_q[LAT-1];
   assign out_data  = d_q[LAT-1];

endmodule

// File: rtl/ram_dp_pipe.sv
// Simple dual-port RAM with byte enables, RD_LAT 1/2, RDW select and post-reset zero sweep.
// Optional per-byte even parity with RAM_DP_PARITY_EN.
module ram_dp_pipe
   import ram_dp_pkg::*;
#(
   parameter int MEM_DEPTH = 32,
   parameter int SIZE      = 8,
   parameter int RD_LAT    = 1,
   parameter int RDW_MODE  = 0,
   localparam int AW       = $clog2(MEM_DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [SIZE-1:0]   data_in,
   input  logic              wren,
   input  logic [SIZE/8-1:0] byteen,
   input  logic [AW-1:0]     wraddress,
   input  logic              rden,
   input  logic [AW-1:0]     rdaddress,
   output logic [SIZE-1:0]   data_out,
   output logic              rd_valid,
   output logic              busy
`ifdef RAM_DP_PARITY_EN
   ,
   output logic              parity_err
`endif
);

   localparam int unsigned NB = SIZE / 8;
`ifdef RAM_DP_PARITY_EN
   localparam int MW = SIZE + SIZE / 8;
   localparam int PW = SIZE + 1;
`else
   localparam int MW = SIZE;
   localparam int PW = SIZE;
`endif
   localparam logic [AW:0]   DEPTH_V  = (AW + 1)'(MEM_DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(MEM_DEPTH - 1);

   if (!(RD_LAT == 1 || RD_LAT == 2) || (SIZE % 8) != 0 || MEM_DEPTH < 2) begin : g_bad_param
      $fatal(1, "ram_dp_pipe: illegal RD_LAT/SIZE/MEM_DEPTH");
   end

   logic [MW-1:0] mem [MEM_DEPTH];

   ram_state_e    state_q, state_d;
   logic [AW-1:0] clr_ptr_q, clr_ptr_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      busy_d    = busy_q;
      if (state_q == CLEAR) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (clr_ptr_q == LAST_PTR) begin
            state_d   = RUN;
            busy_d    = 1'b0;
            clr_ptr_d = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         busy_q    <= busy_d;
      end
   end

   assign busy = busy_q;

   logic run, wr_in_range, rd_in_range, wr_ok, rd_hit;
   assign run         = (state_q == RUN);
   assign wr_in_range = ({1'b0, wraddress} < DEPTH_V);
   assign rd_in_range = ({1'b0, rdaddress} < DEPTH_V);
   assign wr_ok       = run & wren & wr_in_range;
   assign rd_hit      = run & rden;

   // All-zero words already carry correct even parity, so the sweep just writes '0.
   always_ff @(posedge clock) begin
      if (!reset && !run) begin
         mem[clr_ptr_q] <= '0;
      end else if (!reset && wr_ok) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (byteen[i]) begin
               mem[wraddress][8*i +: 8] <= data_in[8*i +: 8];
`ifdef RAM_DP_PARITY_EN
               mem[wraddress][SIZE+i] <= ^data_in[8*i +: 8];
`endif
            end
         end
      end
   end

   logic [MW-1:0] rd_word;

   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
         rd_word = mem[rdaddress];
         if (RDW_MODE == RDW_NEW && wr_ok && wraddress == rdaddress) begin
            for (int unsigned i = 0; i < NB; i++) begin
               if (byteen[i]) begin
                  rd_word[8*i +: 8] = data_in[8*i +: 8];
`ifdef RAM_DP_PARITY_EN
                  rd_word[SIZE+i] = ^data_in[8*i +: 8];
`endif
               end
            end
         end
      end
   end

   logic [PW-1:0] pipe_in, pipe_out;

`ifdef RAM_DP_PARITY_EN
   logic rd_err;
   assign rd_err     = rd_in_range &
                       (|(byte_parity(256'(rd_word[SIZE-1:0]), NB) ^ 32'(rd_word[MW-1:SIZE])));
   assign pipe_in    = {rd_err, rd_word[SIZE-1:0]};
   assign data_out   = pipe_out[SIZE-1:0];
   assign parity_err = pipe_out[SIZE] & rd_valid;
`else
   assign pipe_in    = rd_word;
   assign data_out   = pipe_out;
`endif

   ram_dp_rdpipe #(
      .W      (PW),
      .RD_LAT (RD_LAT)
   ) u_rdpipe (
      .clk       (clock),
      .reset     (reset),
      .in_valid  (rd_hit),
      .in_data   (pipe_in),
      .out_valid (rd_valid),
      .out_data  (pipe_out)
   );

endmodule
